// File: rtl/serial_cmp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : serial_cmp_pkg
// Description : Shared types and fold helpers for the framed serial
//               magnitude comparator.
//               cmp_t    - three-way relation (EQ / LT / GT)
//               fold_msb - merge a new digit relation, most significant first
//               fold_lsb - merge a new digit relation, least significant first
// Revision    : 1.0 - initial release
// ============================================================================
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_LT = 2'd1,
        CMP_GT = 2'd2
    } cmp_t;

    // Higher digits arrive first, so an already decided relation is final.
    function automatic cmp_t fold_msb(cmp_t rel, cmp_t d);
        return (rel == CMP_EQ) ? d : rel;
    endfunction

    // Higher digits arrive last, so any unequal digit overrides the history.
    function automatic cmp_t fold_lsb(cmp_t rel, cmp_t d);
        return (d == CMP_EQ) ? rel : d;
    endfunction

endpackage : serial_cmp_pkg
`default_nettype wire

// File: rtl/serial_cmp_digit.sv
`default_nettype none
// ============================================================================
// Module      : serial_cmp_digit
// Description : Combinational compare of one DIGIT_W-bit digit pair.
//               With SERIAL_CMP_SIGNED_EN defined, the top bit of both
//               digits is inverted on the sign digit so that an unsigned
//               compare orders two's-complement values correctly.
// Ports       : a, b        - operand digits
//               sign_digit  - this digit carries the operand sign
//               d_rel       - relation of a to b for this digit
// Revision    : 1.0 - initial release
// ============================================================================
module serial_cmp_digit
    import serial_cmp_pkg::*;
#(
    parameter int DIGIT_W = 1
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               sign_digit,
    output cmp_t               d_rel
);

    logic [DIGIT_W-1:0] w_a;
    logic [DIGIT_W-1:0] w_b;

`ifdef SERIAL_CMP_SIGNED_EN
    always_comb begin
        w_a = a;
        w_b = b;
        if (sign_digit) begin
            w_a[DIGIT_W-1] = ~a[DIGIT_W-1];
            w_b[DIGIT_W-1] = ~b[DIGIT_W-1];
        end
    end
`else
    logic w_unused_sign;
    assign w_unused_sign = sign_digit;
    assign w_a = a;
    assign w_b = b;
`endif

    always_comb begin
        d_rel = CMP_EQ;
        if (w_a < w_b)
            d_rel = CMP_LT;
        else if (w_a > w_b)
            d_rel = CMP_GT;
    end

endmodule : serial_cmp_digit
`default_nettype wire

// File: rtl/serial_comparator_framed.sv
`default_nettype none
// ============================================================================
// Module      : serial_comparator_framed
// Description : Framed serial magnitude comparator. Two operands of
//               N_DIGITS x DIGIT_W bits arrive one digit per accepted beat,
//               MSB-first or LSB-first (chosen on the first beat of each
//               frame). A registered one-hot result and a one-cycle
//               res_valid pulse follow the last beat.
//               Build option: SERIAL_CMP_SIGNED_EN - two's-complement operands.
// Ports       : clk, rst (async, active high), clear (sync frame abort),
//               in_valid, msb_first, a, b        - beat inputs
//               busy                             - frame in progress
//               res_valid, a_less_b, a_eq_b, a_greater_b - result
// Revision    : 1.0 - initial release
// ============================================================================
module serial_comparator_framed
    import serial_cmp_pkg::*;
#(
    parameter int DIGIT_W  = 1,
    parameter int N_DIGITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               in_valid,
    input  logic               msb_first,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    output logic               busy,
    output logic               res_valid,
    output logic               a_less_b,
    output logic               a_eq_b,
    output logic               a_greater_b
);

    localparam int                CNT_W    = $clog2(N_DIGITS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             ord_q;
    cmp_t             rel_q;

    logic             w_first;
    logic             w_last;
    logic             w_ord;
    logic             w_sign_digit;
    cmp_t             w_rel_in;
    cmp_t             w_d_rel;
    cmp_t             rel_d;

    assign w_first = (cnt_q == '0);
    assign w_last  = (cnt_q == CNT_LAST);
    // The order bit is not latched yet on the first beat, so use the live input.
    assign w_ord   = w_first ? msb_first : ord_q;
    // The sign digit is the most significant one: first in MSB order, last in LSB order.
    assign w_sign_digit = w_ord ? w_first : w_last;
    // A new frame always starts from EQ, whatever relation is left over.
    assign w_rel_in = w_first ? CMP_EQ : rel_q;
    assign rel_d    = w_ord ? fold_msb(w_rel_in, w_d_rel) : fold_lsb(w_rel_in, w_d_rel);

    assign busy = (cnt_q != '0);

    serial_cmp_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .a          (a),
        .b          (b),
        .sign_digit (w_sign_digit),
        .d_rel      (w_d_rel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            ord_q       <= 1'b1;
            rel_q       <= CMP_EQ;
            res_valid   <= 1'b0;
            a_less_b    <= 1'b0;
            a_eq_b      <= 1'b1;
            a_greater_b <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (clear) begin
                cnt_q <= '0;
                rel_q <= CMP_EQ;
            end else if (in_valid) begin
                if (w_first)
                    ord_q <= msb_first;
                if (w_last) begin
                    cnt_q       <= '0;
                    rel_q       <= CMP_EQ;
                    res_valid   <= 1'b1;
                    a_less_b    <= (rel_d == CMP_LT);
                    a_eq_b      <= (rel_d == CMP_EQ);
                    a_greater_b <= (rel_d == CMP_GT);
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    rel_q <= rel_d;
                end
            end
        end
    end

endmodule : serial_comparator_framed
`default_nettype wire

// File: tb/tb_serial_comparator_framed.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_comparator_framed
// Description : Directed self-checking bench. Instance u_dut8 uses
//               DIGIT_W=1/N_DIGITS=8, instance u_dut2 uses DIGIT_W=4/N_DIGITS=2.
//               Expected results follow SERIAL_CMP_SIGNED_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_comparator_framed;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;

    logic       in_valid8 = 1'b0;
    logic       msb8      = 1'b1;
    logic [0:0] a8        = '0;
    logic [0:0] b8        = '0;
    logic       busy8, rv8, lt8, eq8, gt8;

    logic       in_valid2 = 1'b0;
    logic       msb2      = 1'b1;
    logic [3:0] a2        = '0;
    logic [3:0] b2        = '0;
    logic       busy2, rv2, lt2, eq2, gt2;

    int n_checks = 0;
    int n_errors = 0;

    // {res_valid, a_less_b, a_eq_b, a_greater_b}
    localparam logic [3:0] R_LT = 4'b1100;
    localparam logic [3:0] R_EQ = 4'b1010;
    localparam logic [3:0] R_GT = 4'b1001;
`ifdef SERIAL_CMP_SIGNED_EN
    localparam logic [3:0] R_T1 = R_LT;
`else
    localparam logic [3:0] R_T1 = R_GT;
`endif

    always #5 clk = ~clk;

    serial_comparator_framed #(.DIGIT_W(1), .N_DIGITS(8)) u_dut8 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid8),
        .msb_first(msb8), .a(a8), .b(b8), .busy(busy8), .res_valid(rv8),
        .a_less_b(lt8), .a_eq_b(eq8), .a_greater_b(gt8)
    );

    serial_comparator_framed #(.DIGIT_W(4), .N_DIGITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid2),
        .msb_first(msb2), .a(a2), .b(b2), .busy(busy2), .res_valid(rv2),
        .a_less_b(lt2), .a_eq_b(eq2), .a_greater_b(gt2)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one 8-bit frame to u_dut8. A gap cycle follows beat i when gapmask[i].
    // Checks in-frame busy/res_valid after every edge; ends just after the last beat's edge.
    task automatic send8(input string tag, input logic [7:0] A, input logic [7:0] B,
                         input logic msbf, input logic [6:0] gapmask);
        for (int i = 0; i < 8; i++) begin
            int idx;
            idx       = msbf ? 7 - i : i;
            in_valid8 = 1'b1;
            msb8      = (i == 0) ? msbf : ~msbf;  // must be ignored after beat 0
            a8        = A[idx];
            b8        = B[idx];
            tick();
            in_valid8 = 1'b0;
            if (i < 7) begin
                chk({tag, "_inframe"}, {2'b00, rv8, busy8}, 4'b0001);
                if (gapmask[i]) begin
                    tick();
                    chk({tag, "_gap"}, {2'b00, rv8, busy8}, 4'b0001);
                end
            end
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_out8", {rv8, lt8, eq8, gt8}, 4'b0010);
        chk("rst_out2", {rv2, lt2, eq2, gt2}, 4'b0010);
        chk("rst_busy", {2'b00, busy8, busy2}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // MSB-first 0x80 vs 0x7F
        send8("t1", 8'h80, 8'h7F, 1'b1, 7'b0);
        chk("t1_res", {rv8, lt8, eq8, gt8}, R_T1);
        chk("t1_busy", {3'b000, busy8}, 4'b0000);
        tick();
        chk("t1_pulse", {rv8, lt8, eq8, gt8}, {1'b0, R_T1[2:0]});

        // Async reset after 4 beats: outputs drop without a clock edge
        for (int i = 0; i < 4; i++) begin
            in_valid8 = 1'b1; msb8 = 1'b1; a8 = 1'b1; b8 = 1'b0;
            tick();
        end
        in_valid8 = 1'b0;
        chk("rst_mid_busy_pre", {3'b000, busy8}, 4'b0001);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_out", {rv8, lt8, eq8, gt8}, 4'b0010);
        chk("rst_mid_busy", {3'b000, busy8}, 4'b0000);
        rst = 1'b0;
        tick();

        // LSB-first 0x01 vs 0x02, then 0x5A vs 0x5A
        send8("t2", 8'h01, 8'h02, 1'b0, 7'b0);
        chk("t2_res", {rv8, lt8, eq8, gt8}, R_LT);
        send8("t3", 8'h5A, 8'h5A, 1'b0, 7'b0);
        chk("t3_res", {rv8, lt8, eq8, gt8}, R_EQ);
        tick();

        // Gaps: same result as gap-free, pulse only after the last beat
        send8("gap", 8'h80, 8'h7F, 1'b1, 7'b1011011);
        chk("gap_res", {rv8, lt8, eq8, gt8}, R_T1);
        tick();

        // Clear after 3 beats: no pulse, outputs held
        for (int i = 0; i < 3; i++) begin
            in_valid8 = 1'b1; msb8 = 1'b1; a8 = 1'b0; b8 = 1'b1;
            tick();
        end
        in_valid8 = 1'b0;
        clear     = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_out", {rv8, lt8, eq8, gt8}, {1'b0, R_T1[2:0]});
        chk("clr_busy", {3'b000, busy8}, 4'b0000);
        send8("after_clr", 8'h05, 8'h05, 1'b1, 7'b0);
        chk("after_clr_res", {rv8, lt8, eq8, gt8}, R_EQ);
        tick();

        // Clear together with the last beat: beat dropped, no pulse
        for (int i = 0; i < 8; i++) begin
            in_valid8 = 1'b1; msb8 = 1'b1; a8 = 1'b1; b8 = 1'b0;
            clear     = (i == 7);
            tick();
        end
        in_valid8 = 1'b0;
        clear     = 1'b0;
        chk("clr_last", {rv8, lt8, eq8, gt8}, 4'b0010);
        chk("clr_last_busy", {3'b000, busy8}, 4'b0000);
        tick();
        chk("clr_last_after", {rv8, lt8, eq8, gt8}, 4'b0010);

        // Back-to-back on u_dut2: 0x3F vs 0x40 MSB-first, then 0x40 vs 0x3F LSB-first
        in_valid2 = 1'b1; msb2 = 1'b1; a2 = 4'h3; b2 = 4'h4;
        tick();
        chk("b2b_e1", {rv2, 2'b00, busy2}, 4'b0001);
        msb2 = 1'b0; a2 = 4'hF; b2 = 4'h0;
        tick();
        chk("b2b_f1", {rv2, lt2, eq2, gt2}, R_LT);
        msb2 = 1'b0; a2 = 4'h0; b2 = 4'hF;
        tick();
        chk("b2b_e3", {rv2, 2'b00, busy2}, 4'b0001);
        msb2 = 1'b1; a2 = 4'h4; b2 = 4'h3;
        tick();
        in_valid2 = 1'b0;
        chk("b2b_f2", {rv2, lt2, eq2, gt2}, R_GT);
        tick();
        chk("b2b_end", {rv2, 2'b00, busy2}, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_serial_comparator_framed
`default_nettype wire
